// File: rtl/sequence_generator.sv
// Serial pattern generator: shifts a captured pattern out MSB-first for
// repeat_cnt+1 passes, with optional idle-low gaps between passes, then
// emits a single-cycle done pulse. Intended to feed a sequence detector.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for load_valid; load_ready high
// SHIFT  | driving captured pattern[idx] on out, out_valid high
// GAP    | idle-low spacing between passes (GAP_CYCLES cycles)
// DONE   | one-cycle done pulse, then back to IDLE
module sequence_generator #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [WIDTH-1:0]         pattern,
    input  logic [$clog2(WIDTH):0]   length,
    input  logic [3:0]               repeat_cnt,
    input  logic                     abort,
    output logic                     out,
    output logic                     out_valid,
    output logic                     done,
    output logic [2:0]               state
);

    localparam int LW = $clog2(WIDTH) + 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    // Gap timer is a down-counter loaded with GAP_CYCLES-1; terminal count is 0.
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_SHIFT = 3'b001,
        S_GAP   = 3'b010,
        S_DONE  = 3'b011
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_pattern;
    logic [IW-1:0]      r_last_idx;
    logic [IW-1:0]      r_idx;
    logic [3:0]         r_rep;
    logic [GW-1:0]      r_gap;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_pattern_nxt;
    logic [IW-1:0]      w_last_idx_nxt;
    logic [IW-1:0]      w_idx_nxt;
    logic [3:0]         w_rep_nxt;
    logic [GW-1:0]      w_gap_nxt;
    logic [IW-1:0]      w_load_last;

    // Starting index for a new request; a length of 0 (or anything beyond WIDTH) means WIDTH bits.
    always_comb begin
        w_load_last = IW'(WIDTH - 1);
        if (length != '0 && length <= LW'(WIDTH)) begin
            w_load_last = IW'(length - LW'(1));
        end
    end

    // State register and captured transmission context.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pattern  <= '0;
            r_last_idx <= '0;
            r_idx      <= '0;
            r_rep      <= '0;
            r_gap      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pattern  <= w_pattern_nxt;
            r_last_idx <= w_last_idx_nxt;
            r_idx      <= w_idx_nxt;
            r_rep      <= w_rep_nxt;
            r_gap      <= w_gap_nxt;
        end
    end

    // Next-state, datapath updates and Moore outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_pattern_nxt  = r_pattern;
        w_last_idx_nxt = r_last_idx;
        w_idx_nxt      = r_idx;
        w_rep_nxt      = r_rep;
        w_gap_nxt      = r_gap;

        load_ready = (r_state == S_IDLE) && !rst;
        out        = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;
        state      = r_state;

        case (r_state)
            S_IDLE: begin
                if (load_valid && load_ready && !abort) begin
                    w_state_nxt    = S_SHIFT;
                    w_pattern_nxt  = pattern;
                    w_last_idx_nxt = w_load_last;
                    w_idx_nxt      = w_load_last;
                    w_rep_nxt      = repeat_cnt;
                end
            end

            S_SHIFT: begin
                out       = r_pattern[r_idx];
                out_valid = 1'b1;
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_idx == '0) begin
                    if (r_rep != 4'd0) begin
                        w_rep_nxt = r_rep - 4'd1;
                        if (GAP_CYCLES > 0) begin
                            w_state_nxt = S_GAP;
                            w_gap_nxt   = GAP_LOAD;
                        end else begin
                            w_idx_nxt = r_last_idx;
                        end
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_idx_nxt = r_idx - IW'(1);
                end
            end

            S_GAP: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_gap == '0) begin
                    w_state_nxt = S_SHIFT;
                    w_idx_nxt   = r_last_idx;
                end else begin
                    w_gap_nxt = r_gap - GW'(1);
                end
            end

            S_DONE: begin
                // An abort landing here still suppresses the pulse for this transmission.
                done        = !abort;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 Parameter WIDTH, default 8: maximum pattern length in bits.
REQ-002 Parameter GAP_CYCLES, default 1: idle-low cycles inserted between repetitions (0 allowed).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 load_valid  input  1  request to start a transmission.
REQ-006 load_ready  output  1  high when a request can be accepted.
REQ-007 pattern  input  WIDTH  bits to send, MSB-first from bit length-1 down to bit 0.
REQ-008 length  input  $clog2(WIDTH)+1  number of bits sent per repetition; 0 means WIDTH.
REQ-009 repeat_cnt  input  4  extra repetitions; total passes = repeat_cnt+1.
REQ-010 abort  input  1  cancel the current transmission.
REQ-011 out  output  1  serial bit stream for a sequence detector's "in" port.
REQ-012 out_valid  output  1  high while out carries a pattern bit.
REQ-013 done  output  1  one-cycle pulse after the final bit of the final pass.
REQ-014 state  output  3  current FSM state encoding, for debug.

Function
REQ-015 The FSM SHALL have states IDLE=3'b000, SHIFT=3'b001, GAP=3'b010, DONE=3'b011; other codes are unreachable and SHALL return to IDLE on the next edge.
REQ-016 load_ready SHALL be 1 only in IDLE and not during rst.
REQ-017 Acceptance: load_valid && load_ready at edge k SHALL capture pattern, length (0 -> WIDTH), repeat_cnt, and enter SHIFT at k.
REQ-018 In SHIFT, out SHALL equal captured pattern[idx] and out_valid=1; idx starts at length-1 and decrements each cycle.
REQ-019 First bit SHALL appear in the cycle after acceptance (latency 1); one bit per cycle, no bubbles within a pass.
REQ-020 At idx=0 with passes remaining: go to GAP if GAP_CYCLES>0, else reload idx=length-1 and stay in SHIFT (back-to-back passes).
REQ-021 GAP SHALL last exactly GAP_CYCLES cycles with out=0, out_valid=0, then SHIFT with idx=length-1.
REQ-022 At idx=0 with no passes remaining: go to DONE; DONE lasts one cycle with done=1, then IDLE.
REQ-023 Outside SHIFT, out=0 and out_valid=0.
REQ-024 Repetition counter SHALL decrement once per completed pass; repeat_cnt=15 yields 16 passes with no wrap-around.
REQ-025 load_valid outside IDLE SHALL be ignored; input changes after acceptance SHALL NOT affect the transmission in flight.
REQ-026 abort=1 in SHIFT, GAP or DONE SHALL force IDLE on the next edge: out=0, out_valid=0, done never asserted for that transmission.
REQ-027 abort and load_valid both high in IDLE: abort wins, request not accepted.
REQ-028 A request held high in DONE SHALL be accepted in the following IDLE cycle (one idle cycle minimum between transmissions).

Reset
REQ-029 rst=1 at an edge SHALL force state=IDLE, out=0, out_valid=0, done=0, idx and counters to 0, and SHALL override abort and load_valid.
REQ-030 While rst=1, load_ready=0; after rst falls, load_ready=1 in the first cycle.
REQ-031 rst mid-transmission SHALL discard the transmission with no done pulse.

Verification
REQ-032 pattern=8'b0000_1011, length=4, repeat_cnt=0, accept at edge k -> out=1,0,1,1 in cycles k+1..k+4 with out_valid=1; done=1 at k+5; IDLE at k+6.
REQ-033 Same pattern, repeat_cnt=1, GAP_CYCLES=2 -> bits k+1..k+4, out=0/out_valid=0 at k+5..k+6, bits k+7..k+10, done at k+11.
REQ-034 GAP_CYCLES=0, pattern 3'b101, length=3, repeat_cnt=2 -> 9 contiguous valid bits 101101101, single done pulse.
REQ-035 length=0, pattern=8'hA5 -> 8 bits 10100101 MSB-first, then done.
REQ-036 abort pulsed during bit 3 of a 4-bit pass -> IDLE next cycle, out_valid=0, no done; new request accepted the cycle after.
REQ-037 rst asserted during GAP -> state=000, all outputs 0 next edge; load_valid held in IDLE without rst -> ignored in SHIFT, accepted only after DONE.
